// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// SPI pin bundle: master modport drives SCK/CS/MOSI, slave modport drives MISO.
interface spi_master_cfg_if #(parameter int NUM_CS = 1);
    logic              spi_sck;
    logic [NUM_CS-1:0] spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (output spi_sck, spi_cs_n, spi_mosi, input spi_miso);
    modport slave  (input spi_sck, spi_cs_n, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator; counter is parked at zero while disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 5
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       cnt <= '0;
        else if (!en || tick) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: configurable width, divider, mode, bit order and CS count.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int CLK_DIV   = 5,
    parameter int NUM_CS    = 1,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CS_W     = cs_width(NUM_CS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    spi_master_cfg_if.master  spi
);
    localparam int CNT_W = $clog2(2*DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*DATA_W - 1);
    localparam logic [1:0] MODE = {CPOL, CPHA};
    localparam bit LEAD_SAMPLE = (MODE == MODE0) || (MODE == MODE2);

    spi_state_e        state, state_n;
    logic              tick, lead, last_tick;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              sck, mosi;
    logic [NUM_CS-1:0] cs_n;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (state != IDLE),
        .tick      (tick)
    );

    // bit_cnt holds ticks already taken, so an even count means the next tick is leading
    assign lead      = ~bit_cnt[0];
    assign last_tick = (bit_cnt == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)             state_n = SETUP;
            SETUP:   if (tick)              state_n = XFER;
            XFER:    if (tick && last_tick) state_n = HOLD;
            HOLD:    if (tick)              state_n = IDLE;
            default:                        state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck     <= CPOL;
            cs_n    <= '1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    tx_sh   <= tx_data;
                    rx_sh   <= '0;
                    bit_cnt <= '0;
                    // out-of-range selects match no line, so the frame runs with CS idle
                    for (int i = 0; i < NUM_CS; i++) cs_n[i] <= (cs_sel != CS_W'(i));
                    if (!CPHA) mosi <= first_bit(tx_data);
                end
                XFER: if (tick) begin
                    sck     <= ~sck;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (lead) begin
                        if (LEAD_SAMPLE) rx_sh <= shift_in(rx_sh, spi.spi_miso);
                        else begin
                            mosi  <= first_bit(tx_sh);
                            tx_sh <= shift_out(tx_sh);
                        end
                    end else begin
                        if (!LEAD_SAMPLE) rx_sh <= shift_in(rx_sh, spi.spi_miso);
                        else if (!last_tick) begin
                            mosi  <= first_bit(shift_out(tx_sh));
                            tx_sh <= shift_out(tx_sh);
                        end
                    end
                end
                HOLD: if (tick) begin
                    cs_n    <= '1;
                    mosi    <= 1'b0;
                    rx_data <= rx_sh;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign spi.spi_sck  = sck;
    assign spi.spi_cs_n = cs_n;
    assign spi.spi_mosi = mosi;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg across four parameterisations.
module tb_spi_master_cfg;
    import spi_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int chk = 0;
    int fails = 0;

    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
    logic [23:0] tx0 = '0;
    logic [7:0]  tx1 = '0, tx2 = '0;
    logic [1:0]  tx3 = '0;
    logic [0:0]  cs0 = '0;
    logic [cs_width(3)-1:0] cs3 = '0;
    logic busy0, busy1, busy2, busy3, done0, done1, done2, done3;
    logic [23:0] rx0;
    logic [7:0]  rx1, rx2;
    logic [1:0]  rx3;

    spi_master_cfg_if #(.NUM_CS(1)) bus0();
    spi_master_cfg_if #(.NUM_CS(1)) bus1();
    spi_master_cfg_if #(.NUM_CS(1)) bus2();
    spi_master_cfg_if #(.NUM_CS(3)) bus3();

    assign bus0.spi_miso = bus0.spi_mosi;
    assign bus3.spi_miso = bus3.spi_mosi;

    spi_master_cfg u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0), .tx_data(tx0), .cs_sel(cs0),
        .busy(busy0), .done(done0), .rx_data(rx0), .spi(bus0)
    );
    spi_master_cfg #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .tx_data(tx1), .cs_sel(cs0),
        .busy(busy1), .done(done1), .rx_data(rx1), .spi(bus1)
    );
    spi_master_cfg #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .tx_data(tx2), .cs_sel(cs0),
        .busy(busy2), .done(done2), .rx_data(rx2), .spi(bus2)
    );
    spi_master_cfg #(.DATA_W(2), .CLK_DIV(2), .NUM_CS(3)) u3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start3), .tx_data(tx3), .cs_sel(cs3),
        .busy(busy3), .done(done3), .rx_data(rx3), .spi(bus3)
    );

    // Mode-3 slaves: drive MISO on the falling (leading) edge, u1 MSB first, u2 LSB first
    logic [7:0] sl1 = 8'h3C, sl2 = 8'h3C;
    int idx1 = 0, idx2 = 0;
    always @(negedge bus1.spi_sck or posedge bus1.spi_cs_n[0])
        if (bus1.spi_cs_n[0]) idx1 = 0;
        else begin bus1.spi_miso = sl1[7-idx1]; idx1++; end
    always @(negedge bus2.spi_sck or posedge bus2.spi_cs_n[0])
        if (bus2.spi_cs_n[0]) idx2 = 0;
        else begin bus2.spi_miso = sl2[idx2]; idx2++; end

    // MOSI as seen by a slave on the rising SCK edge, first bit ends up in the MSB
    logic [23:0] mo0 = '0;
    logic [7:0]  mo1 = '0, mo2 = '0;
    always @(posedge bus0.spi_sck) if (bus0.spi_cs_n[0] === 1'b0) mo0 = {mo0[22:0], bus0.spi_mosi};
    always @(posedge bus1.spi_sck) if (bus1.spi_cs_n[0] === 1'b0) mo1 = {mo1[6:0], bus1.spi_mosi};
    always @(posedge bus2.spi_sck) if (bus2.spi_cs_n[0] === 1'b0) mo2 = {mo2[6:0], bus2.spi_mosi};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int w, input logic s, input logic [23:0] tx, input logic [1:0] cs);
        case (w)
            0:       begin start0 = s; tx0 = tx; end
            1:       begin start1 = s; tx1 = tx[7:0]; end
            2:       begin start2 = s; tx2 = tx[7:0]; end
            default: begin start3 = s; tx3 = tx[1:0]; cs3 = cs; end
        endcase
    endtask

    function automatic logic done_of(input int w);
        case (w) 0: return done0; 1: return done1; 2: return done2; default: return done3; endcase
    endfunction
    function automatic logic busy_of(input int w);
        case (w) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
    endfunction
    function automatic logic sck_of(input int w);
        case (w)
            0: return bus0.spi_sck; 1: return bus1.spi_sck; 2: return bus2.spi_sck;
            default: return bus3.spi_sck;
        endcase
    endfunction
    function automatic logic [7:0] csn_of(input int w);
        case (w)
            0: return {7'h7F, bus0.spi_cs_n}; 1: return {7'h7F, bus1.spi_cs_n};
            2: return {7'h7F, bus2.spi_cs_n}; default: return {5'h1F, bus3.spi_cs_n};
        endcase
    endfunction

    // Issue one frame and follow it to done; inj re-pulses start at that cycle, and
    // tx/cs are scrambled every cycle of the frame
    task automatic run(input int w, input logic [23:0] tx, input logic [1:0] cs, input int inj,
                       input bit now, output int cyc, output int csl, output int sckh,
                       output int edges, output bit busy_ok, output logic [7:0] cs_first);
        logic psck;
        if (!now) @(negedge sys_clk);
        set_req(w, 1'b1, tx, cs);
        @(negedge sys_clk);
        set_req(w, 1'b0, tx, cs);
        cyc = 1; csl = 0; sckh = 0; edges = 0; busy_ok = 1'b1;
        cs_first = csn_of(w);
        psck = sck_of(w);
        while (!done_of(w) && cyc < 2000) begin
            if (!busy_of(w)) busy_ok = 1'b0;
            if (csn_of(w) != 8'hFF) csl++;
            if (sck_of(w)) sckh++;
            @(negedge sys_clk);
            cyc++;
            if (sck_of(w) != psck) edges++;
            psck = sck_of(w);
            set_req(w, cyc == inj, ~tx, cs ^ 2'b01);
        end
    endtask

    int cyc, csl, sckh, edges;
    bit busy_ok;
    logic [7:0] csf;

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_cs_n0", 32'(bus0.spi_cs_n), 32'h1);
        check("rst_mosi0", 32'(bus0.spi_mosi), 32'h0);
        check("rst_sck0",  32'(bus0.spi_sck),  32'h0);
        check("rst_sck1",  32'(bus1.spi_sck),  32'h1);
        check("rst_cs_n3", 32'(bus3.spi_cs_n), 32'h7);
        check("rst_flags", 32'({busy0, done0}), 32'h0);
        check("rst_rx0",   32'(rx0), 32'h0);
        sys_rst_n = 1'b1;

        // mode 0, 24 bits, loopback
        run(0, 24'h84E6B7, 2'd0, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("m0_done_cyc", 32'(cyc), 32'd251);
        check("m0_rx",       32'(rx0), 32'h84E6B7);
        check("m0_mosi",     32'(mo0), 32'h84E6B7);
        check("m0_sck_edges", 32'(edges), 32'd48);
        check("m0_busy",     32'(busy_ok), 32'h1);
        check("m0_busy_at_done", 32'(busy0), 32'h0);
        check("m0_cs_first", 32'(csf), 32'hFE);
        check("m0_cs_low",   32'(csl), 32'd250);
        @(negedge sys_clk);
        check("m0_done_pulse", 32'(done0), 32'h0);
        check("m0_rx_hold",    32'(rx0), 32'h84E6B7);

        // mode 3, 8 bits, MSB first
        run(1, 24'h0000A5, 2'd0, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("m3_done_cyc", 32'(cyc), 32'd91);
        check("m3_rx",       32'(rx1), 32'h3C);
        check("m3_mosi",     32'(mo1), 32'hA5);
        check("m3_sck_edges", 32'(edges), 32'd16);
        check("m3_sck_idle", 32'(bus1.spi_sck), 32'h1);

        // mode 3, LSB first
        run(2, 24'h0000A5, 2'd0, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("lsb_rx_a",   32'(rx2), 32'h3C);
        check("lsb_mosi_a", 32'(mo2), 32'hA5);
        sl2 = 8'h01;
        run(2, 24'h000001, 2'd0, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("lsb_rx_b",   32'(rx2), 32'h01);
        check("lsb_mosi_b", 32'(mo2), 32'h80);
        check("lsb_done_cyc", 32'(cyc), 32'd91);

        // start re-pulsed mid-frame, then back-to-back frame
        run(0, 24'h123456, 2'd0, 100, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("mid_done_cyc", 32'(cyc), 32'd251);
        check("mid_busy",     32'(busy_ok), 32'h1);
        check("mid_rx",       32'(rx0), 32'h123456);
        check("b2b_cs_hi",    32'(bus0.spi_cs_n), 32'h1);
        run(0, 24'h0F0F0F, 2'd0, 0, 1'b1, cyc, csl, sckh, edges, busy_ok, csf);
        check("b2b_cs_first", 32'(csf), 32'hFE);
        check("b2b_done_cyc", 32'(cyc), 32'd251);
        check("b2b_rx",       32'(rx0), 32'h0F0F0F);

        // async reset at XFER tick 10
        @(negedge sys_clk);
        set_req(0, 1'b1, 24'hFFFFFF, 2'd0);
        @(negedge sys_clk);
        set_req(0, 1'b0, 24'hFFFFFF, 2'd0);
        repeat (55) @(posedge sys_clk);
        #1;
        check("rr_busy_pre", 32'(busy0), 32'h1);
        sys_rst_n = 1'b0;
        #1;
        check("rr_cs_n", 32'(bus0.spi_cs_n), 32'h1);
        check("rr_sck",  32'(bus0.spi_sck), 32'h0);
        check("rr_busy", 32'(busy0), 32'h0);
        check("rr_rx",   32'(rx0), 32'h0);
        repeat (2) @(negedge sys_clk);
        check("rr_no_done", 32'(done0), 32'h0);
        sys_rst_n = 1'b1;
        run(0, 24'h5A3C96, 2'd0, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("rr_done_cyc", 32'(cyc), 32'd251);
        check("rr_rx_after", 32'(rx0), 32'h5A3C96);

        // NUM_CS=3, CLK_DIV=2, DATA_W=2
        run(3, 24'h000002, 2'd2, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("cs2_first",    32'(csf), 32'hFB);
        check("cs2_low_cyc",  32'(csl), 32'd12);
        check("cs2_done_cyc", 32'(cyc), 32'd13);
        check("cs2_sck_high", 32'(sckh), 32'd4);
        check("cs2_sck_edges", 32'(edges), 32'd4);
        check("cs2_rx",       32'(rx3), 32'h2);
        run(3, 24'h000001, 2'd3, 0, 1'b0, cyc, csl, sckh, edges, busy_ok, csf);
        check("cs3_first",    32'(csf), 32'hFF);
        check("cs3_low_cyc",  32'(csl), 32'd0);
        check("cs3_done_cyc", 32'(cyc), 32'd13);
        check("cs3_rx",       32'(rx3), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised, full-duplex SPI master; next generation of the team's fixed 24-bit, mode-0, transmit-only SPI master.
- Adds:
  - configurable frame width and SCK divider
  - CPOL/CPHA mode selection
  - MISO capture
  - multiple chip selects
  - a start/busy/done handshake, so frames are sent on request rather than once.
- Sits between a register/control FSM on sys_clk and external SPI slaves (DAC/ADC/config devices).
- Everything, including SCK, is registered in the sys_clk domain.

Parameters:
- DATA_W, 24: bits per frame, 2..64.
- CLK_DIV, 5: sys_clk cycles per SCK half-period, >=2. 50 MHz / (2*5) = 5 MHz SCK.
- NUM_CS, 1: number of chip-select lines, 1..8.
- CPOL, 0: SCK idle level.
- CPHA, 0:
  - 0: sample on leading edge, shift on trailing edge.
  - 1: shift on leading edge, sample on trailing edge.
- MSB_FIRST, 1: 1 = bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  transfer request, sampled on posedge sys_clk.
- tx_data  in  DATA_W  frame to send, latched when start is accepted.
- cs_sel  in  CS_W=max(1,$clog2(NUM_CS))  chip-select index, latched with tx_data.
- busy  out  1  high from the cycle after acceptance until the cycle done pulses.
- done  out  1  one-cycle pulse at frame end.
- rx_data  out  DATA_W  captured MISO frame; valid when done is high; held until next done.
- spi_sck  out  1  serial clock, registered.
- spi_cs_n  out  NUM_CS  active-low chip selects, registered.
- spi_mosi  out  1  serial data out, registered.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - state=IDLE; spi_sck=CPOL; spi_cs_n all 1; spi_mosi=0.
  - busy=0, done=0, rx_data=0; divider counter=0.
- Divider:
  - Counts 0..CLK_DIV-1 only while state != IDLE.
  - Produces a one-cycle tick at CLK_DIV-1.
  - Held at 0 in IDLE.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - start=1 is accepted: latch tx_data into shift register and cs_sel; go to SETUP.
  - Next cycle: busy=1 and selected spi_cs_n low.
  - CPHA=0 only: spi_mosi is driven with the first bit in that same cycle.
- SETUP: lasts one half-period (CLK_DIV cycles), SCK idle; on tick go to XFER.
- XFER: 2*DATA_W ticks, each tick toggles spi_sck.
  - Odd ticks are leading edges; even ticks are trailing edges.
  - CPHA=0: leading edge samples spi_miso into rx shift register; trailing edge shifts next bit onto mosi, except after the last bit.
  - CPHA=1: leading edge drives next bit onto mosi; trailing edge samples.
  - After tick 2*DATA_W, spi_sck is back at CPOL; go to HOLD.
- HOLD: one half-period, SCK idle, CS still asserted. On tick:
  - spi_cs_n all 1, spi_mosi=0.
  - rx_data <= rx shift register; done=1 for one cycle; busy=0 in the same cycle; go to IDLE.
- Latency: start sampled at edge 0 -> done high in cycle (2*DATA_W+2)*CLK_DIV+1.
  - Defaults: 251 cycles.
- Back-to-back: start may be accepted in the cycle after done, giving a minimum CS-high gap of 1 sys_clk.
- Ignored requests:
  - start while busy is ignored; no queuing.
  - tx_data/cs_sel changes during a frame have no effect.
- cs_sel >= NUM_CS: frame runs with identical timing, no CS line asserted, done still pulses.
- Bit counter width is $clog2(2*DATA_W+1). No wrap inside a frame.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE/SETUP/XFER/HOLD)
  - mode constants MODE0..MODE3 as {CPOL,CPHA}
  - function for CS_W
- Sub-module spi_clk_div: half-period tick generator with enable, parameter CLK_DIV.
- The rest (FSM, shift registers, CS decode) lives in spi_master_cfg.

Test Plan:
- Defaults (mode 0, DATA_W=24), tx_data=0x84E6B7, miso looped to mosi:
  - mosi bits 1000_0100_1110_0110_1011_0111, MSB first, stable at each SCK rising edge.
  - rx_data=0x84E6B7; done at cycle 251; 24 SCK pulses of 10 cycles each.
- CPOL=1, CPHA=1, DATA_W=8, tx=0xA5, slave model returns 0x3C:
  - SCK idles high; mosi changes on falling edges.
  - rx_data=0x3C; MSB_FIRST=0 variant sends 1010_0101 reversed (1,0,1,0,0,1,0,1 from bit 0).
- start pulsed again mid-frame:
  - Ignored; exactly one done; busy continuous; second start after done accepted with 1-cycle CS-high gap.
- sys_rst_n low at XFER tick 10:
  - Same cycle: spi_cs_n=all 1, spi_sck=CPOL, busy=0, no done.
  - After release, a new frame completes normally.
- NUM_CS=4:
  - cs_sel=2 -> only spi_cs_n[2] low for (2*DATA_W+2)*CLK_DIV cycles.
  - cs_sel=5 (CS_W=2 -> value 1, so use NUM_CS=3 with cs_sel=3) -> no CS asserted, done still pulses.
- CLK_DIV=2, DATA_W=2:
  - done at cycle 13; SCK high/low each 2 cycles; no glitch on spi_sck.
